// File: rtl/reg_ctrl.sv
// 128 x 16-bit configuration/status register file, six requesters, fixed-priority write port.
// Optional build macro REG_CTRL_PORT_PROTECT_EN: restricts switch-port writes to 0x10-0x1F.
module reg_ctrl (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         spi_req,
   input  logic [6:0]   spi_addr,
   input  logic [15:0]  spi_din,
   output logic         spi_ack,
   output logic [15:0]  spi_dout,
   input  logic         ttehash_req,
   output logic         ttehash_ack,
   input  logic         port0_req,
   input  logic [6:0]   port0_addr,
   input  logic [15:0]  port0_din,
   output logic         port0_ack,
   input  logic         port1_req,
   input  logic [6:0]   port1_addr,
   input  logic [15:0]  port1_din,
   output logic         port1_ack,
   input  logic         port2_req,
   input  logic [6:0]   port2_addr,
   input  logic [15:0]  port2_din,
   output logic         port2_ack,
   input  logic         port3_req,
   input  logic [6:0]   port3_addr,
   input  logic [15:0]  port3_din,
   output logic         port3_ack,
   output logic         r_hash_clear,
   output logic         r_hash_update,
   output logic [127:0] r_flow_mux,
   output logic [9:0]   r_hash
);

`ifdef REG_CTRL_PORT_PROTECT_EN
   localparam bit PROTECT = 1'b1;
`else
   localparam bit PROTECT = 1'b0;
`endif

   logic [15:0] regs [0:127];
   logic [5:0]  req_vec;
   logic [5:0]  ack_vec;
   logic [5:0]  elig;
   logic [5:0]  grant;
   logic        wr_en;
   logic [6:0]  wr_addr;
   logic [15:0] wr_data;

   function automatic logic port_ok(input logic [6:0] a);
      return !PROTECT || (a[6:4] == 3'b001);
   endfunction

   // bit 0 is the highest-priority requester (spi); the ack mask blocks a re-grant
   assign req_vec = {port3_req, port2_req, port1_req, port0_req, ttehash_req, spi_req};
   assign elig    = req_vec & ~ack_vec;
   assign grant   = elig & (~elig + 6'd1);

   always_comb begin
      wr_en   = 1'b0;
      wr_addr = spi_addr;
      wr_data = spi_din;
      if (grant[0]) begin
         wr_en = 1'b1;
      end else if (grant[2]) begin
         wr_addr = port0_addr;
         wr_data = port0_din;
         wr_en   = port_ok(port0_addr);
      end else if (grant[3]) begin
         wr_addr = port1_addr;
         wr_data = port1_din;
         wr_en   = port_ok(port1_addr);
      end else if (grant[4]) begin
         wr_addr = port2_addr;
         wr_data = port2_din;
         wr_en   = port_ok(port2_addr);
      end else if (grant[5]) begin
         wr_addr = port3_addr;
         wr_data = port3_din;
         wr_en   = port_ok(port3_addr);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 128; i++) regs[i] <= '0;
         ack_vec  <= '0;
         spi_dout <= '0;
      end else begin
         ack_vec <= grant;
         if (wr_en) regs[wr_addr] <= wr_data;
         // hash engine consumed the update: clear only the two handshake bits
         if (grant[1]) regs[0][1:0] <= 2'b00;
         if (grant[0]) spi_dout <= regs[spi_addr];
      end
   end

   assign spi_ack       = ack_vec[0];
   assign ttehash_ack   = ack_vec[1];
   assign port0_ack     = ack_vec[2];
   assign port1_ack     = ack_vec[3];
   assign port2_ack     = ack_vec[4];
   assign port3_ack     = ack_vec[5];

   assign r_hash_clear  = regs[0][0];
   assign r_hash_update = regs[0][1];
   assign r_hash        = regs[1][9:0];
   assign r_flow_mux    = {regs[9], regs[8], regs[7], regs[6],
                           regs[5], regs[4], regs[3], regs[2]};

endmodule

// File: tb/tb_reg_ctrl.sv
// Self-checking bench for reg_ctrl: SPI write table plus arbitration/reset/handshake sequences.
module tb_reg_ctrl;

`ifdef REG_CTRL_PORT_PROTECT_EN
   localparam bit PROT = 1'b1;
`else
   localparam bit PROT = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         spi_req, ttehash_req, port0_req, port1_req, port2_req, port3_req;
   logic [6:0]   spi_addr, port0_addr, port1_addr, port2_addr, port3_addr;
   logic [15:0]  spi_din, port0_din, port1_din, port2_din, port3_din;
   logic         spi_ack, ttehash_ack, port0_ack, port1_ack, port2_ack, port3_ack;
   logic [15:0]  spi_dout;
   logic         r_hash_clear, r_hash_update;
   logic [127:0] r_flow_mux;
   logic [9:0]   r_hash;

   reg_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .spi_req(spi_req), .spi_addr(spi_addr), .spi_din(spi_din),
      .spi_ack(spi_ack), .spi_dout(spi_dout),
      .ttehash_req(ttehash_req), .ttehash_ack(ttehash_ack),
      .port0_req(port0_req), .port0_addr(port0_addr), .port0_din(port0_din), .port0_ack(port0_ack),
      .port1_req(port1_req), .port1_addr(port1_addr), .port1_din(port1_din), .port1_ack(port1_ack),
      .port2_req(port2_req), .port2_addr(port2_addr), .port2_din(port2_din), .port2_ack(port2_ack),
      .port3_req(port3_req), .port3_addr(port3_addr), .port3_din(port3_din), .port3_ack(port3_ack),
      .r_hash_clear(r_hash_clear), .r_hash_update(r_hash_update),
      .r_flow_mux(r_flow_mux), .r_hash(r_hash)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  addr;
      logic [15:0] din;
      logic [15:0] exp_dout;
   } vec_t;

   vec_t        vecs [10];
   logic [15:0] model [128];
   logic [15:0] dout_q [$];
   logic [5:0]  ack_q [$];
   int          n_cmp = 0;
   int          n_err = 0;

   wire [5:0] acks = {port3_ack, port2_ack, port1_ack, port0_ack, ttehash_ack, spi_ack};

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] exp_flow();
      logic [127:0] e;
      for (int i = 0; i < 8; i++) e[i*16 +: 16] = model[2+i];
      return e;
   endfunction

   task automatic check_decoded(input string tag);
      check({tag, "_flow"},   r_flow_mux,    exp_flow());
      check({tag, "_hash"},   r_hash,        model[1][9:0]);
      check({tag, "_clear"},  r_hash_clear,  model[0][0]);
      check({tag, "_update"}, r_hash_update, model[0][1]);
   endtask

   // Starts and ends just after a falling edge; assumes no competing requester.
   task automatic spi_write(input logic [6:0] a, input logic [15:0] d,
                            input logic [15:0] exp_dout, input string tag);
      int lat;
      logic [15:0] e;
      spi_req  = 1'b1;
      spi_addr = a;
      spi_din  = d;
      dout_q.push_back(exp_dout);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!spi_ack && lat < 8);
      check({tag, "_lat"}, lat, 1);
      spi_req = 1'b0;
      e = dout_q.pop_front();
      check({tag, "_dout"}, spi_dout, e);
      model[a] = d;
      @(negedge clk);
      check({tag, "_ackfall"}, spi_ack, 1'b0);
      check({tag, "_douthold"}, spi_dout, e);
      check_decoded(tag);
   endtask

   initial begin
      int lat;
      logic [2:0] pat;
      rst_n = 1'b0;
      spi_req = 0; ttehash_req = 0; port0_req = 0; port1_req = 0; port2_req = 0; port3_req = 0;
      spi_addr = 0; port0_addr = 0; port1_addr = 0; port2_addr = 0; port3_addr = 0;
      spi_din = 0; port0_din = 0; port1_din = 0; port2_din = 0; port3_din = 0;
      for (int i = 0; i < 128; i++) model[i] = 16'h0;

      vecs[0] = '{7'h02, 16'h0055, 16'h0000};
      vecs[1] = '{7'h02, 16'h1234, 16'h0055};
      vecs[2] = '{7'h01, 16'h03FF, 16'h0000};
      vecs[3] = '{7'h09, 16'hABCD, 16'h0000};
      vecs[4] = '{7'h09, 16'h0000, 16'hABCD};
      vecs[5] = '{7'h7F, 16'hBEEF, 16'h0000};
      vecs[6] = '{7'h7F, 16'h0001, 16'hBEEF};
      vecs[7] = '{7'h05, 16'hFFFF, 16'h0000};
      vecs[8] = '{7'h04, 16'h2222, 16'h1111};
      vecs[9] = '{7'h01, 16'h0155, 16'h03FF};

      // reset state
      repeat (10) @(negedge clk);
      check("rst_acks", acks, 6'b0);
      check("rst_dout", spi_dout, 16'h0);
      check_decoded("rst");
      rst_n = 1'b1;
      @(negedge clk);

      // reset in the middle of an SPI ack, req kept high through reset
      spi_req = 1'b1; spi_addr = 7'h04; spi_din = 16'h1111;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!spi_ack && lat < 8);
      check("midrst_lat", lat, 1);
      check("midrst_dout", spi_dout, 16'h0);
      rst_n = 1'b0;
      #1;
      check("midrst_ackdrop", spi_ack, 1'b0);
      check("midrst_flow", r_flow_mux, 128'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rearb_ack", spi_ack, 1'b1);
      check("rearb_dout", spi_dout, 16'h0);
      spi_req = 1'b0;
      model[4] = 16'h1111;
      check_decoded("rearb");
      @(negedge clk);

      // table of uncontended SPI writes
      for (int i = 0; i < 10; i++)
         spi_write(vecs[i].addr, vecs[i].din, vecs[i].exp_dout, $sformatf("vec%0d", i));

      // hash control bits and ttehash clear
      spi_write(7'h00, 16'h0F03, model[0], "ctrl_set");
      ttehash_req = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!ttehash_ack && lat < 8);
      check("tte_lat", lat, 1);
      ttehash_req = 1'b0;
      model[0][1:0] = 2'b00;
      @(negedge clk);
      check("tte_ackfall", ttehash_ack, 1'b0);
      check_decoded("tte");
      spi_write(7'h00, 16'h0000, 16'h0F00, "ctrl_rb");

      // four-way contention
      spi_req = 1'b1; spi_addr = 7'h20; spi_din = 16'h7777;
      ttehash_req = 1'b1;
      port0_req = 1'b1; port0_addr = 7'h10; port0_din = 16'h0010;
      port1_req = 1'b1; port1_addr = 7'h13; port1_din = 16'h0011;
      ack_q.push_back(6'b000001);
      ack_q.push_back(6'b000010);
      ack_q.push_back(6'b000100);
      ack_q.push_back(6'b001000);
      model[7'h20] = 16'h7777;
      model[7'h10] = 16'h0010;
      model[7'h13] = 16'h0011;
      for (int c = 0; c < 10 && ack_q.size() > 0; c++) begin
         @(negedge clk);
         if (acks != 6'b0) begin
            check("arb_order", acks, ack_q.pop_front());
            if (spi_ack)     spi_req     = 1'b0;
            if (ttehash_ack) ttehash_req = 1'b0;
            if (port0_ack)   port0_req   = 1'b0;
            if (port1_ack)   port1_req   = 1'b0;
         end
      end
      check("arb_done", ack_q.size(), 0);
      spi_req = 0; ttehash_req = 0; port0_req = 0; port1_req = 0;
      @(negedge clk);
      spi_write(7'h10, 16'h0000, 16'h0010, "rb10");
      spi_write(7'h13, 16'h0000, 16'h0011, "rb13");
      spi_write(7'h20, 16'h0000, 16'h7777, "rb20");

      // held port2 request: grant, gap, grant
      port2_req = 1'b1; port2_addr = 7'h15; port2_din = 16'h00AA;
      pat = 3'b101;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("p2_hold%0d", i), port2_ack, pat[2-i]);
      end
      port2_req = 1'b0;
      model[7'h15] = 16'h00AA;
      @(negedge clk);
      check("p2_end", port2_ack, 1'b0);
      spi_write(7'h15, 16'h0000, 16'h00AA, "rb15");

      // port3 write to a flow-mux register (discarded when protected)
      port3_req = 1'b1; port3_addr = 7'h02; port3_din = 16'hFFFF;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!port3_ack && lat < 8);
      check("p3_lat", lat, 1);
      port3_req = 1'b0;
      if (!PROT) model[2] = 16'hFFFF;
      @(negedge clk);
      check("p3_ackfall", port3_ack, 1'b0);
      check_decoded("p3");

      // port1 withdraws while SPI holds the grant
      spi_req = 1'b1; spi_addr = 7'h30; spi_din = 16'h4444;
      port1_req = 1'b1; port1_addr = 7'h03; port1_din = 16'h5A5A;
      @(negedge clk);
      check("wd_spi_ack", spi_ack, 1'b1);
      spi_req = 1'b0;
      port1_req = 1'b0;
      model[7'h30] = 16'h4444;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("wd_p1_ack%0d", i), port1_ack, 1'b0);
      end
      check_decoded("wd");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
